// File: rtl/icache_core_if.sv
// Handshake and debug bundle between the instruction cache and its neighbours
// (ITLB, L2 cache, IFU). The slave modport is the cache side.
interface icache_core_if #(
  parameter int unsigned PA_W   = 34,
  parameter int unsigned LINE_W = 256
);
  // ITLB request side
  logic              i_Itlb_drive;
  logic [PA_W-1:0]   i_Itlb_PA_34;
  logic              o_Itlb_free;
  // L2 miss request and refill
  logic              o_driveNext_L2Cache;
  logic [PA_W-1:0]   o_miss_Addr_to_L2cache_34;
  logic              i_freeNext_L2Cache;
  logic              o_L2Cache_free;
  logic              i_L2Cache_drive;
  logic [LINE_W-1:0] i_L2Cache_refillLine_32B;
  // IFU response
  logic              o_driveNext_ifu;
  logic [LINE_W-1:0] o_hit_data_to_ifu_32B;
  logic              i_freeNext_ifu;
  // Debug observation
  logic [1:0]        o_fifo_buffer_write_enable_2;
  logic [PA_W-1:0]   o_fifo2_1_addr_34;
  logic              o_write_enable;
  logic              o_fifo_buffer_data_out;

  modport master (
    output i_Itlb_drive, i_Itlb_PA_34, i_freeNext_L2Cache, i_L2Cache_drive,
           i_L2Cache_refillLine_32B, i_freeNext_ifu,
    input  o_Itlb_free, o_driveNext_L2Cache, o_miss_Addr_to_L2cache_34, o_L2Cache_free,
           o_driveNext_ifu, o_hit_data_to_ifu_32B, o_fifo_buffer_write_enable_2,
           o_fifo2_1_addr_34, o_write_enable, o_fifo_buffer_data_out
  );

  modport slave (
    input  i_Itlb_drive, i_Itlb_PA_34, i_freeNext_L2Cache, i_L2Cache_drive,
           i_L2Cache_refillLine_32B, i_freeNext_ifu,
    output o_Itlb_free, o_driveNext_L2Cache, o_miss_Addr_to_L2cache_34, o_L2Cache_free,
           o_driveNext_ifu, o_hit_data_to_ifu_32B, o_fifo_buffer_write_enable_2,
           o_fifo2_1_addr_34, o_write_enable, o_fifo_buffer_data_out
  );
endinterface

// File: rtl/icache_core.sv
// Two-way set-associative L1 instruction cache, one request in flight.
// Hits return the whole line two cycles after the request; misses fetch the
// line-aligned address from L2, fill the victim way and forward the line.
module icache_core #(
  parameter int unsigned PA_W   = 34,
  parameter int unsigned LINE_W = 256,
  parameter int unsigned SETS   = 128,
  parameter int unsigned WAYS   = 2
) (
  input  logic         clk,
  input  logic         rst,
  icache_core_if.slave bus
);
  localparam int unsigned OFF_W = $clog2(LINE_W / 8);
  localparam int unsigned IDX_W = $clog2(SETS);
  localparam int unsigned TAG_W = PA_W - IDX_W - OFF_W;

  localparam logic [2:0] StIdle       = 3'd0;
  localparam logic [2:0] StLookup     = 3'd1;
  localparam logic [2:0] StMissReq    = 3'd2;
  localparam logic [2:0] StWaitRefill = 3'd3;
  localparam logic [2:0] StResp       = 3'd4;

  logic [2:0]            state;
  logic [PA_W-1:0]       req_pa;
  logic [PA_W-1:0]       miss_addr;
  logic [LINE_W-1:0]     ifu_data;
  logic                  drive_ifu;
  logic                  drive_l2;
  logic                  hit_flag;
  logic                  array_we;
  logic [1:0]            way_we;

  // Storage: valid and LRU are reset, tag and data are not.
  logic [WAYS-1:0][SETS-1:0] valid;
  logic [SETS-1:0]           lru;  // way to evict next in each set
  logic [TAG_W-1:0]          tag_mem  [WAYS][SETS];
  logic [LINE_W-1:0]         data_mem [WAYS][SETS];

  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic             hit0, hit1, hit_any;
  logic             hit_way;
  logic             victim;
  logic             refill_fire;

  // Tag compare and victim selection for the latched request.
  always_comb begin
    idx         = req_pa[OFF_W +: IDX_W];
    tag         = req_pa[PA_W-1 -: TAG_W];
    hit0        = valid[0][idx] && (tag_mem[0][idx] == tag);
    hit1        = valid[1][idx] && (tag_mem[1][idx] == tag);
    hit_any     = hit0 || hit1;
    hit_way     = hit1;
    if (!valid[0][idx])      victim = 1'b0;
    else if (!valid[1][idx]) victim = 1'b1;
    else                     victim = lru[idx];
    refill_fire = (state == StWaitRefill) && bus.i_L2Cache_drive;
  end

  // Control FSM, handshake pulses and output data registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= StIdle;
      valid     <= '0;
      lru       <= '0;
      req_pa    <= '0;
      miss_addr <= '0;
      ifu_data  <= '0;
      drive_ifu <= 1'b0;
      drive_l2  <= 1'b0;
      hit_flag  <= 1'b0;
      array_we  <= 1'b0;
      way_we    <= 2'b00;
    end else begin
      drive_ifu <= 1'b0;
      drive_l2  <= 1'b0;
      array_we  <= 1'b0;
      way_we    <= 2'b00;
      case (state)
        StIdle: begin
          if (bus.i_Itlb_drive) begin
            req_pa <= bus.i_Itlb_PA_34;
            state  <= StLookup;
          end
        end
        StLookup: begin
          if (hit_any) begin
            ifu_data  <= hit_way ? data_mem[1][idx] : data_mem[0][idx];
            drive_ifu <= 1'b1;
            hit_flag  <= 1'b1;
            lru[idx]  <= ~hit_way;
            state     <= StResp;
          end else begin
            miss_addr <= {req_pa[PA_W-1:OFF_W], {OFF_W{1'b0}}};
            drive_l2  <= 1'b1;
            hit_flag  <= 1'b0;
            state     <= StMissReq;
          end
        end
        StMissReq: begin
          if (bus.i_freeNext_L2Cache) state <= StWaitRefill;
        end
        StWaitRefill: begin
          if (refill_fire) begin
            valid[victim][idx] <= 1'b1;
            lru[idx]           <= ~victim;
            ifu_data           <= bus.i_L2Cache_refillLine_32B;
            drive_ifu          <= 1'b1;
            array_we           <= 1'b1;
            way_we             <= victim ? 2'b10 : 2'b01;
            state              <= StResp;
          end
        end
        StResp: begin
          if (bus.i_freeNext_ifu) state <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

  // Tag and data array writes on refill acceptance.
  always_ff @(posedge clk) begin
    if (!rst && refill_fire) begin
      tag_mem[victim][idx]  <= tag;
      data_mem[victim][idx] <= bus.i_L2Cache_refillLine_32B;
    end
  end

  assign bus.o_Itlb_free                  = (state == StIdle);
  assign bus.o_L2Cache_free               = (state == StWaitRefill);
  assign bus.o_driveNext_L2Cache          = drive_l2;
  assign bus.o_miss_Addr_to_L2cache_34    = miss_addr;
  assign bus.o_driveNext_ifu              = drive_ifu;
  assign bus.o_hit_data_to_ifu_32B        = ifu_data;
  assign bus.o_fifo_buffer_write_enable_2 = way_we;
  assign bus.o_fifo2_1_addr_34            = req_pa;
  assign bus.o_write_enable               = array_we;
  assign bus.o_fifo_buffer_data_out       = hit_flag;
endmodule

// File: tb/tb_icache_core.sv
// Bench for icache_core: directed table of fetches through one set, reset and
// stray-pulse sequences, then random fetches against a timestamp-LRU model.
module tb_icache_core;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  icache_core_if bus ();
  icache_core dut (.clk(clk), .rst(rst), .bus(bus));

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [33:0]  pa;
    logic [255:0] line;
    bit           hit;
    logic [1:0]   we;
    logic [255:0] data;
  } vec_t;

  vec_t vecs[7];

  // Reference model: per-set ways with last-touch timestamps
  bit           m_valid [128][2];
  logic [21:0]  m_tag   [128][2];
  logic [255:0] m_data  [128][2];
  int           m_stamp [128][2];
  int           now_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] rand_line();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  task automatic clear_inputs();
    bus.i_Itlb_drive             = 1'b0;
    bus.i_Itlb_PA_34             = '0;
    bus.i_freeNext_L2Cache       = 1'b0;
    bus.i_L2Cache_drive          = 1'b0;
    bus.i_L2Cache_refillLine_32B = '0;
    bus.i_freeNext_ifu           = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag_s);
    check({tag_s, "_itlb_free"}, 256'(bus.o_Itlb_free), 256'd1);
    check({tag_s, "_l2_pulse"}, 256'(bus.o_driveNext_L2Cache), 256'd0);
    check({tag_s, "_ifu_pulse"}, 256'(bus.o_driveNext_ifu), 256'd0);
    check({tag_s, "_l2_free"}, 256'(bus.o_L2Cache_free), 256'd0);
    check({tag_s, "_we"}, 256'(bus.o_write_enable), 256'd0);
    check({tag_s, "_way_we"}, 256'(bus.o_fifo_buffer_write_enable_2), 256'd0);
  endtask

  // One complete fetch with the expected outcome supplied by the caller.
  task automatic do_fetch(input logic [33:0] pa, input logic [255:0] line, input bit exp_hit,
                          input logic [1:0] exp_we, input logic [255:0] exp_data,
                          input int d1, input int d2, input int d3);
    check("start_free", 256'(bus.o_Itlb_free), 256'd1);
    bus.i_Itlb_PA_34 = pa;
    bus.i_Itlb_drive = 1'b1;
    tick();
    bus.i_Itlb_drive = 1'b0;
    check("lookup_busy", 256'(bus.o_Itlb_free), 256'd0);
    tick();
    check("addr_latch", 256'(bus.o_fifo2_1_addr_34), 256'(pa));
    check("ifu_pulse", 256'(bus.o_driveNext_ifu), 256'(exp_hit));
    check("l2_pulse", 256'(bus.o_driveNext_L2Cache), 256'(!exp_hit));
    check("hit_flag", 256'(bus.o_fifo_buffer_data_out), 256'(exp_hit));
    if (!exp_hit) begin
      check("miss_addr", 256'(bus.o_miss_Addr_to_L2cache_34), 256'({pa[33:5], 5'b0}));
      for (int i = 0; i < d1; i++) begin
        bus.i_L2Cache_drive          = 1'b1;
        bus.i_L2Cache_refillLine_32B = ~line;
        bus.i_freeNext_ifu           = 1'b1;
        tick();
        bus.i_L2Cache_drive = 1'b0;
        bus.i_freeNext_ifu  = 1'b0;
        check("missreq_stray_ifu", 256'(bus.o_driveNext_ifu), 256'd0);
        check("missreq_l2_free", 256'(bus.o_L2Cache_free), 256'd0);
      end
      bus.i_freeNext_L2Cache = 1'b1;
      tick();
      bus.i_freeNext_L2Cache = 1'b0;
      check("refill_l2_free", 256'(bus.o_L2Cache_free), 256'd1);
      check("miss_addr_held", 256'(bus.o_miss_Addr_to_L2cache_34), 256'({pa[33:5], 5'b0}));
      for (int i = 0; i < d2; i++) tick();
      bus.i_L2Cache_refillLine_32B = line;
      bus.i_L2Cache_drive          = 1'b1;
      tick();
      bus.i_L2Cache_drive          = 1'b0;
      bus.i_L2Cache_refillLine_32B = rand_line();
      check("refill_ifu_pulse", 256'(bus.o_driveNext_ifu), 256'd1);
      check("refill_we", 256'(bus.o_write_enable), 256'd1);
      check("refill_way_we", 256'(bus.o_fifo_buffer_write_enable_2), 256'(exp_we));
      check("refill_l2_free", 256'(bus.o_L2Cache_free), 256'd0);
    end
    check("ifu_data", bus.o_hit_data_to_ifu_32B, exp_data);
    for (int i = 0; i < d3; i++) begin
      bus.i_Itlb_PA_34 = ~pa;
      bus.i_Itlb_drive = 1'b1;
      tick();
      bus.i_Itlb_drive = 1'b0;
      check("resp_hold_data", bus.o_hit_data_to_ifu_32B, exp_data);
      check("resp_no_pulse", 256'(bus.o_driveNext_ifu), 256'd0);
      check("resp_addr_held", 256'(bus.o_fifo2_1_addr_34), 256'(pa));
    end
    bus.i_freeNext_ifu = 1'b1;
    tick();
    bus.i_freeNext_ifu = 1'b0;
    check("end_free", 256'(bus.o_Itlb_free), 256'd1);
    check("end_we", 256'(bus.o_write_enable), 256'd0);
  endtask

  // Model-driven fetch: the model decides hit/miss, victim way and data.
  task automatic model_fetch(input logic [33:0] pa);
    int           s;
    logic [21:0]  t;
    int           w;
    bit           hit;
    logic [255:0] line;
    logic [255:0] exp_data;
    s    = int'(pa[11:5]);
    t    = pa[33:12];
    line = rand_line();
    hit  = 1'b0;
    w    = 0;
    for (int k = 0; k < 2; k++)
      if (m_valid[s][k] && m_tag[s][k] == t) begin
        hit = 1'b1;
        w   = k;
      end
    if (!hit) begin
      if (!m_valid[s][0])      w = 0;
      else if (!m_valid[s][1]) w = 1;
      else                     w = (m_stamp[s][0] < m_stamp[s][1]) ? 0 : 1;
      m_valid[s][w] = 1'b1;
      m_tag[s][w]   = t;
      m_data[s][w]  = line;
    end
    exp_data = m_data[s][w];
    now_t++;
    m_stamp[s][w] = now_t;
    do_fetch(pa, line, hit, (w == 1) ? 2'b10 : 2'b01, exp_data,
             $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2));
  endtask

  // Watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [33:0]  pa_a, pa_b, pa_c;
    logic [255:0] la, lb, lc;
    logic [21:0]  tags [4];
    logic [6:0]   sets [3];
    pa_a = 34'h234567abc;
    pa_b = 34'h256789abc;
    pa_c = 34'h111111abc;
    la = 256'hfea5bf5c_11223344_55667788_99aabbcc_ddeeff00_13579bdf_2468ace0_5e91b527;
    lb = 256'h1c7e7580_0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0_deadbeef_cafef00d_637f1a83;
    lc = 256'h0badc0de_a5a5a5a5_5a5a5a5a_01234567_89abcdef_fedcba98_76543210_c001d00d;

    // Set 0x55 walk: fill both ways, hit both, third tag evicts the LRU way.
    vecs[0] = '{pa_a, la, 1'b0, 2'b01, la};
    vecs[1] = '{pa_b, lb, 1'b0, 2'b10, lb};
    vecs[2] = '{pa_a, lc, 1'b1, 2'b00, la};
    vecs[3] = '{pa_b, lc, 1'b1, 2'b00, lb};
    vecs[4] = '{pa_c, lc, 1'b0, 2'b01, lc};
    vecs[5] = '{pa_b, la, 1'b1, 2'b00, lb};
    vecs[6] = '{pa_a, la, 1'b0, 2'b01, la};

    clear_inputs();
    repeat (150) tick();
    rst = 1'b0;
    check_idle_outputs("reset");
    check("reset_miss_addr", 256'(bus.o_miss_Addr_to_L2cache_34), 256'd0);
    check("reset_ifu_data", bus.o_hit_data_to_ifu_32B, 256'd0);
    check("reset_addr", 256'(bus.o_fifo2_1_addr_34), 256'd0);
    check("reset_hit_flag", 256'(bus.o_fifo_buffer_data_out), 256'd0);

    for (int i = 0; i < 7; i++)
      do_fetch(vecs[i].pa, vecs[i].line, vecs[i].hit, vecs[i].we, vecs[i].data, i % 3,
               (i + 1) % 3, (i + 2) % 3);

    // Stray pulses while idle are ignored.
    bus.i_L2Cache_drive = 1'b1;
    tick();
    bus.i_L2Cache_drive    = 1'b0;
    check_idle_outputs("stray_l2_drive");
    bus.i_freeNext_L2Cache = 1'b1;
    bus.i_freeNext_ifu     = 1'b1;
    tick();
    bus.i_freeNext_L2Cache = 1'b0;
    bus.i_freeNext_ifu     = 1'b0;
    check_idle_outputs("stray_frees");

    // Reset while waiting for a refill aborts cleanly and drops all lines.
    bus.i_Itlb_PA_34 = pa_c;
    bus.i_Itlb_drive = 1'b1;
    tick();
    bus.i_Itlb_drive = 1'b0;
    tick();
    check("abort_l2_pulse", 256'(bus.o_driveNext_L2Cache), 256'd1);
    bus.i_freeNext_L2Cache = 1'b1;
    tick();
    bus.i_freeNext_L2Cache = 1'b0;
    check("abort_wait_refill", 256'(bus.o_L2Cache_free), 256'd1);
    rst = 1'b1;
    bus.i_L2Cache_drive          = 1'b1;
    bus.i_L2Cache_refillLine_32B = lc;
    tick();
    bus.i_L2Cache_drive = 1'b0;
    rst = 1'b0;
    check_idle_outputs("abort");
    tick();
    check_idle_outputs("abort_next");
    do_fetch(pa_a, lb, 1'b0, 2'b01, lb, 0, 0, 0);
    do_fetch(pa_b, la, 1'b0, 2'b10, la, 1, 1, 1);

    // Random phase from a clean reset against the model.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    now_t = 0;
    for (int s = 0; s < 128; s++)
      for (int k = 0; k < 2; k++) begin
        m_valid[s][k] = 1'b0;
        m_stamp[s][k] = 0;
      end
    tags[0] = 22'h234567;
    tags[1] = 22'h256789;
    tags[2] = 22'h111111;
    tags[3] = 22'h3fffff;
    sets[0] = 7'h55;
    sets[1] = 7'h00;
    sets[2] = 7'h7f;
    for (int n = 0; n < 80; n++) begin
      logic [4:0] off;
      off = 5'($urandom());
      model_fetch({tags[$urandom_range(0, 3)], sets[$urandom_range(0, 2)], off});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
